// File: rtl/data_in_serializer_pkg.sv
// Shared sizing constants for the input-side chunk serializer and its chunk mux.
// Word width follows the number format used across the datapath (BIT_LENGTH * DATA_N).
package data_in_serializer_pkg;

   localparam int BIT_LENGTH    = 8;
   localparam int DATA_N        = 2;
   localparam int WORD_W_DEF    = BIT_LENGTH * DATA_N;
   localparam int FRAME_LEN_DEF = 102;
   localparam int N_CHUNK_DEF   = 4;

endpackage

// File: rtl/data_chunk_sel.sv
// Combinational mux that picks one WORD_W chunk out of an N_CHUNK-word vector.
// Chunk k occupies bits [(k+1)*WORD_W-1 : k*WORD_W]; an out-of-range index yields zero.
module data_chunk_sel
   import data_in_serializer_pkg::*;
#(
   parameter int WORD_W  = WORD_W_DEF,
   parameter int N_CHUNK = N_CHUNK_DEF,
   parameter int CHUNK_W = $clog2(N_CHUNK)
) (
   input  logic [N_CHUNK*WORD_W-1:0] i_vec,
   input  logic [CHUNK_W-1:0]        i_idx,
   output logic [WORD_W-1:0]         o_word
);

   always_comb begin
      o_word = '0;
      for (int k = 0; k < N_CHUNK; k++) begin
         if (i_idx == CHUNK_W'(k)) begin
            o_word = i_vec[k*WORD_W +: WORD_W];
         end
      end
   end

endmodule

// File: rtl/data_in_serializer.sv
// Double-buffered vector-to-word serializer with valid/ready on both sides and fixed-length
// output frames; a frame end discards the rest of the current vector so frames start on chunk 0.
module data_in_serializer
   import data_in_serializer_pkg::*;
#(
   parameter int WORD_W    = WORD_W_DEF,
   parameter int N_CHUNK   = N_CHUNK_DEF,
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int CHUNK_W   = $clog2(N_CHUNK)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_run,
   input  logic                      i_in_valid,
   output logic                      o_in_ready,
   input  logic [N_CHUNK*WORD_W-1:0] i_in_data,
   output logic                      o_out_valid,
   input  logic                      i_out_ready,
   output logic [WORD_W-1:0]         o_out_data,
   output logic [CHUNK_W-1:0]        o_out_chunk,
   output logic                      o_out_last,
   output logic                      o_frame_done,
   output logic [15:0]               o_frame_cnt
);

   localparam int BEAT_W = $clog2(FRAME_LEN);
   localparam int VEC_W  = N_CHUNK * WORD_W;
   localparam logic [CHUNK_W-1:0] LAST_IDX  = CHUNK_W'(N_CHUNK - 1);
   localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

   logic [VEC_W-1:0]   r_pendData;
   logic               r_pendV;
   logic [VEC_W-1:0]   r_actData;
   logic               r_actV;
   logic [CHUNK_W-1:0] r_idx;
   logic [BEAT_W-1:0]  r_beat;
   logic               r_inReady;
   logic               r_outValid;
   logic [WORD_W-1:0]  r_outData;
   logic [CHUNK_W-1:0] r_outChunk;
   logic               r_outLast;
   logic               r_frameDone;
   logic [15:0]        r_frameCnt;

   logic               w_adv;
   logic               w_load;
   logic               w_frameEnd;
   logic               w_consume;
   logic               w_promote;
   logic               w_accept;
   logic               w_pendVNext;
   logic               w_lastHs;
   logic [WORD_W-1:0]  w_word;

   data_chunk_sel #(
      .WORD_W  (WORD_W),
      .N_CHUNK (N_CHUNK),
      .CHUNK_W (CHUNK_W)
   ) u_chunkSel (
      .i_vec  (r_actData),
      .i_idx  (r_idx),
      .o_word (w_word)
   );

   // A loaded word consumes the active vector on its last chunk or on the frame's last beat.
   always_comb begin
      w_adv       = !r_outValid || i_out_ready;
      w_load      = w_adv && r_actV;
      w_frameEnd  = w_load && (r_beat == LAST_BEAT);
      w_consume   = w_load && ((r_idx == LAST_IDX) || (r_beat == LAST_BEAT));
      w_promote   = r_pendV && (!r_actV || w_consume);
      w_accept    = i_in_valid && r_inReady;
      w_pendVNext = (r_pendV && !w_promote) || w_accept;
      w_lastHs    = r_outValid && i_out_ready && r_outLast;
   end

   // Low run flushes everything except the completed-frame counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pendData  <= '0;
         r_pendV     <= 1'b0;
         r_actData   <= '0;
         r_actV      <= 1'b0;
         r_idx       <= '0;
         r_beat      <= '0;
         r_inReady   <= 1'b0;
         r_outValid  <= 1'b0;
         r_outData   <= '0;
         r_outChunk  <= '0;
         r_outLast   <= 1'b0;
         r_frameDone <= 1'b0;
         r_frameCnt  <= '0;
      end else if (!i_run) begin
         r_pendV     <= 1'b0;
         r_actV      <= 1'b0;
         r_idx       <= '0;
         r_beat      <= '0;
         r_inReady   <= 1'b0;
         r_outValid  <= 1'b0;
         r_outData   <= '0;
         r_outChunk  <= '0;
         r_outLast   <= 1'b0;
         r_frameDone <= 1'b0;
      end else begin
         if (w_accept) begin
            r_pendData <= i_in_data;
         end
         r_pendV   <= w_pendVNext;
         r_inReady <= !w_pendVNext;
         if (w_promote) begin
            r_actData <= r_pendData;
         end
         r_actV <= w_promote || (r_actV && !w_consume);
         if (w_adv) begin
            r_outValid <= r_actV;
            if (r_actV) begin
               r_outData  <= w_word;
               r_outChunk <= r_idx;
               r_outLast  <= (r_beat == LAST_BEAT);
               if (w_frameEnd) begin
                  r_beat <= '0;
                  r_idx  <= '0;
               end else begin
                  r_beat <= r_beat + 1'b1;
                  r_idx  <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
               end
            end
         end
         r_frameDone <= w_lastHs;
         if (w_lastHs) begin
            r_frameCnt <= r_frameCnt + 16'd1;
         end
      end
   end

   assign o_in_ready   = r_inReady;
   assign o_out_valid  = r_outValid;
   assign o_out_data   = r_outData;
   assign o_out_chunk  = r_outChunk;
   assign o_out_last   = r_outLast;
   assign o_frame_done = r_frameDone;
   assign o_frame_cnt  = r_frameCnt;

endmodule

// File: tb/tb_data_in_serializer.sv
// Self-checking bench: default-parameter instance checked every cycle against a beat-queue model,
// plus a small-parameter instance (3 chunks, 7-beat frames) checked with literal expectations.
module tb_data_in_serializer;

   localparam int A_N  = 4;
   localparam int A_FL = 102;
   localparam int B_N  = 3;
   localparam int B_FL = 7;

   typedef struct {
      logic [15:0] data;
      logic [1:0]  chunk;
      logic        last;
   } beat_t;

   logic        clk;
   logic        rst_n;

   logic        aRun, aInValid, aInReady, aOutValid, aOutReady, aOutLast, aFrameDone;
   logic [63:0] aInData;
   logic [15:0] aOutData, aFrameCnt;
   logic [1:0]  aOutChunk;

   logic        bRun, bInValid, bInReady, bOutValid, bOutReady, bOutLast, bFrameDone;
   logic [47:0] bInData;
   logic [15:0] bOutData, bFrameCnt;
   logic [1:0]  bOutChunk;

   int          testsRun;
   int          failCount;
   int          cycleCount;

   beat_t       expQ[$];
   beat_t       e;
   int          mBeat;
   int          mCnt;
   logic        expDone;
   logic        prevFlush;
   logic        prevHold;
   logic [15:0] holdData;
   logic [1:0]  holdChunk;
   logic        holdLast;

   logic        logOn;
   logic [15:0] logData[$];
   logic        logLast[$];
   int          logCyc[$];

   logic [15:0] bLogData[$];
   logic        bLogLast[$];
   logic        bDone;

   data_in_serializer #(.WORD_W(16), .N_CHUNK(A_N), .FRAME_LEN(A_FL)) dutA (
      .clk(clk), .rst_n(rst_n), .i_run(aRun), .i_in_valid(aInValid), .o_in_ready(aInReady),
      .i_in_data(aInData), .o_out_valid(aOutValid), .i_out_ready(aOutReady),
      .o_out_data(aOutData), .o_out_chunk(aOutChunk), .o_out_last(aOutLast),
      .o_frame_done(aFrameDone), .o_frame_cnt(aFrameCnt)
   );

   data_in_serializer #(.WORD_W(16), .N_CHUNK(B_N), .FRAME_LEN(B_FL)) dutB (
      .clk(clk), .rst_n(rst_n), .i_run(bRun), .i_in_valid(bInValid), .o_in_ready(bInReady),
      .i_in_data(bInData), .o_out_valid(bOutValid), .i_out_ready(bOutReady),
      .o_out_data(bOutData), .o_out_chunk(bOutChunk), .o_out_last(bOutLast),
      .o_frame_done(bFrameDone), .o_frame_cnt(bFrameCnt)
   );

   // Free-running clock and a cycle counter used to measure gaps between beats.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mkVec(input int v);
      logic [63:0] r;
      r = '0;
      for (int k = 0; k < A_N; k++) r[k*16 +: 16] = {v[11:0], k[3:0]};
      return r;
   endfunction

   function automatic logic [47:0] mkVecB(input int v);
      logic [47:0] r;
      r = '0;
      for (int k = 0; k < B_N; k++) r[k*16 +: 16] = {v[11:0], k[3:0]};
      return r;
   endfunction

   // An accepted vector yields its chunks in order, cut short at the frame's last beat.
   function automatic void pushVector(input logic [63:0] v);
      for (int k = 0; k < A_N; k++) begin
         beat_t b;
         b.data  = v[k*16 +: 16];
         b.chunk = k[1:0];
         b.last  = (mBeat == A_FL - 1);
         expQ.push_back(b);
         if (b.last) begin
            mBeat = 0;
            break;
         end
         mBeat++;
      end
   endfunction

   // Reference model and per-cycle comparison for instance A, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         expQ.delete();
         mBeat     = 0;
         mCnt      = 0;
         expDone   = 1'b0;
         prevFlush = 1'b0;
         prevHold  = 1'b0;
      end else begin
         checkOutput("frame_done", {63'd0, aFrameDone}, {63'd0, expDone});
         checkOutput("frame_cnt", {48'd0, aFrameCnt}, 64'(mCnt % 65536));
         if (prevFlush) begin
            checkOutput("flush_out_valid", {63'd0, aOutValid}, 64'd0);
            checkOutput("flush_in_ready", {63'd0, aInReady}, 64'd0);
            checkOutput("flush_out_data", {48'd0, aOutData}, 64'd0);
         end
         if (prevHold) begin
            checkOutput("stall_data", {48'd0, aOutData}, {48'd0, holdData});
            checkOutput("stall_chunk", {62'd0, aOutChunk}, {62'd0, holdChunk});
            checkOutput("stall_last", {63'd0, aOutLast}, {63'd0, holdLast});
         end
         expDone = 1'b0;
         if (!aRun) begin
            expQ.delete();
            mBeat     = 0;
            prevFlush = 1'b1;
            prevHold  = 1'b0;
         end else begin
            prevFlush = 1'b0;
            prevHold  = aOutValid && !aOutReady;
            holdData  = aOutData;
            holdChunk = aOutChunk;
            holdLast  = aOutLast;
            if (aOutValid && aOutReady) begin
               if (logOn) begin
                  logData.push_back(aOutData);
                  logLast.push_back(aOutLast);
                  logCyc.push_back(cycleCount);
               end
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_beat", {63'd0, aOutValid}, 64'd0);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("beat_data", {48'd0, aOutData}, {48'd0, e.data});
                  checkOutput("beat_chunk", {62'd0, aOutChunk}, {62'd0, e.chunk});
                  checkOutput("beat_last", {63'd0, aOutLast}, {63'd0, e.last});
                  if (e.last) begin
                     expDone = 1'b1;
                     mCnt++;
                  end
               end
            end
            if (aInValid && aInReady) pushVector(aInData);
         end
      end
   end

   // Random per-cycle drive of instance A; percentages set the chance of each input being high/low.
   task automatic applyStimulus(input int cycles, input int validPct, input int readyPct,
                                input int runLowPct);
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
         aInValid  = ($urandom_range(99) < validPct);
         aOutReady = ($urandom_range(99) < readyPct);
         aRun      = !($urandom_range(99) < runLowPct);
         aInData   = {$urandom, $urandom};
      end
   endtask

   task automatic drainA(input string name);
      logic drained;
      drained = 1'b0;
      @(posedge clk);
      #1;
      aInValid  = 1'b0;
      aOutReady = 1'b1;
      aRun      = 1'b1;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (expQ.size() == 0 && !aOutValid) begin
            drained = 1'b1;
            break;
         end
      end
      checkOutput(name, {63'd0, drained}, 64'd1);
   endtask

   // Instance B: continuous input, record the first beats for literal checks.
   initial begin
      logic accB;
      int   bVec;
      bRun      = 1'b1;
      bInValid  = 1'b0;
      bOutReady = 1'b1;
      bInData   = '0;
      bDone     = 1'b0;
      bVec      = 0;
      wait (rst_n === 1'b1);
      @(posedge clk);
      #1;
      bInValid = 1'b1;
      bInData  = mkVecB(0);
      for (int c = 0; c < 200 && bLogData.size() < 9; c++) begin
         @(negedge clk);
         if (bOutValid && bOutReady) begin
            bLogData.push_back(bOutData);
            bLogLast.push_back(bOutLast);
         end
         accB = bInValid && bInReady;
         @(posedge clk);
         #1;
         if (accB) begin
            bVec++;
            bInData = mkVecB(bVec);
         end
      end
      bInValid = 1'b0;
      bDone    = 1'b1;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic        acc;
      int          vec;
      logic [15:0] stallData;
      logic [15:0] cntBefore;
      logic        seen;
      int          lastCount;

      testsRun  = 0;
      failCount = 0;
      cycleCount = 0;
      logOn     = 1'b0;
      rst_n     = 1'b0;
      aRun      = 1'b0;
      aInValid  = 1'b0;
      aOutReady = 1'b0;
      aInData   = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_out_valid", {63'd0, aOutValid}, 64'd0);
      checkOutput("rst_in_ready", {63'd0, aInReady}, 64'd0);
      checkOutput("rst_frame_cnt", {48'd0, aFrameCnt}, 64'd0);
      rst_n = 1'b1;
      aRun  = 1'b1;
      @(negedge clk);
      checkOutput("ready_before_edge", {63'd0, aInReady}, 64'd0);
      @(negedge clk);
      checkOutput("ready_after_run", {63'd0, aInReady}, 64'd1);

      // Single vector: chunks appear two cycles after acceptance
      @(posedge clk);
      #1;
      aInValid  = 1'b1;
      aInData   = 64'h4444_3333_2222_1111;
      aOutReady = 1'b1;
      @(posedge clk);
      #1;
      aInValid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("single_valid0", {63'd0, aOutValid}, 64'd1);
      checkOutput("single_word0", {48'd0, aOutData}, 64'h1111);
      checkOutput("single_chunk0", {62'd0, aOutChunk}, 64'd0);
      @(negedge clk);
      checkOutput("single_word1", {48'd0, aOutData}, 64'h2222);
      @(negedge clk);
      checkOutput("single_word2", {48'd0, aOutData}, 64'h3333);
      @(negedge clk);
      checkOutput("single_word3", {48'd0, aOutData}, 64'h4444);
      checkOutput("single_chunk3", {62'd0, aOutChunk}, 64'd3);
      @(negedge clk);
      checkOutput("single_idle", {63'd0, aOutValid}, 64'd0);

      // Flush to restart the frame at beat 0
      @(posedge clk);
      #1;
      aRun = 1'b0;
      @(posedge clk);
      #1;
      aRun = 1'b1;
      @(negedge clk);
      checkOutput("flush1_frame_cnt", {48'd0, aFrameCnt}, 64'd0);

      // Continuous input across a frame boundary
      @(posedge clk);
      #1;
      vec      = 0;
      aInValid = 1'b1;
      aInData  = mkVec(0);
      logOn    = 1'b1;
      for (int c = 0; c < 400 && logData.size() < 110; c++) begin
         @(negedge clk);
         acc = aInValid && aInReady;
         @(posedge clk);
         #1;
         if (acc) begin
            vec++;
            aInData = mkVec(vec);
         end
      end
      aInValid = 1'b0;
      logOn    = 1'b0;
      checkOutput("cont_beats_logged", {63'd0, logData.size() >= 110}, 64'd1);
      if (logData.size() >= 110) begin
         lastCount = 0;
         for (int i = 0; i < 103; i++) if (logLast[i]) lastCount++;
         checkOutput("cont_beat100", {48'd0, logData[100]}, 64'h0190);
         checkOutput("cont_beat101", {48'd0, logData[101]}, 64'h0191);
         checkOutput("cont_beat101_last", {63'd0, logLast[101]}, 64'd1);
         checkOutput("cont_beat102", {48'd0, logData[102]}, 64'h01A0);
         checkOutput("cont_last_count", 64'(lastCount), 64'd1);
         checkOutput("cont_no_bubbles", 64'(logCyc[109] - logCyc[0]), 64'd109);
      end
      drainA("cont_drain");
      checkOutput("cont_frame_cnt", {48'd0, aFrameCnt}, 64'd1);

      // Backpressure: hold out_ready low for five cycles mid-vector
      applyStimulus(6, 100, 100, 0);
      applyStimulus(1, 100, 0, 0);
      @(negedge clk);
      stallData = aOutData;
      checkOutput("bp_valid", {63'd0, aOutValid}, 64'd1);
      applyStimulus(4, 100, 0, 0);
      @(negedge clk);
      checkOutput("bp_data_stable", {48'd0, aOutData}, {48'd0, stallData});
      checkOutput("bp_in_ready_low", {63'd0, aInReady}, 64'd0);
      applyStimulus(8, 100, 100, 0);
      drainA("bp_drain");

      // Flush mid-frame, then restart with a fresh vector
      applyStimulus(20, 100, 100, 0);
      @(posedge clk);
      #1;
      cntBefore = aFrameCnt;
      aRun      = 1'b0;
      aInValid  = 1'b0;
      @(posedge clk);
      #1;
      aRun = 1'b1;
      @(negedge clk);
      checkOutput("midflush_valid", {63'd0, aOutValid}, 64'd0);
      checkOutput("midflush_in_ready", {63'd0, aInReady}, 64'd0);
      checkOutput("midflush_data", {48'd0, aOutData}, 64'd0);
      checkOutput("midflush_cnt", {48'd0, aFrameCnt}, {48'd0, cntBefore});
      @(posedge clk);
      #1;
      aInValid = 1'b1;
      aInData  = mkVec(12'h077);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         acc = aInValid && aInReady;
         @(posedge clk);
         #1;
         if (acc) begin
            aInValid = 1'b0;
            break;
         end
      end
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (aOutValid) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("restart_seen", {63'd0, seen}, 64'd1);
      checkOutput("restart_chunk", {62'd0, aOutChunk}, 64'd0);
      checkOutput("restart_data", {48'd0, aOutData}, 64'h0770);
      drainA("restart_drain");

      // Randomized traffic, with and without occasional flushes
      applyStimulus(1500, 80, 75, 0);
      applyStimulus(1500, 70, 70, 1);
      drainA("random_drain");

      // Asynchronous reset mid-stream
      applyStimulus(30, 100, 100, 0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("async_out_valid", {63'd0, aOutValid}, 64'd0);
      checkOutput("async_in_ready", {63'd0, aInReady}, 64'd0);
      checkOutput("async_out_data", {48'd0, aOutData}, 64'd0);
      checkOutput("async_out_chunk", {62'd0, aOutChunk}, 64'd0);
      checkOutput("async_out_last", {63'd0, aOutLast}, 64'd0);
      checkOutput("async_frame_done", {63'd0, aFrameDone}, 64'd0);
      checkOutput("async_frame_cnt", {48'd0, aFrameCnt}, 64'd0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      aRun     = 1'b1;
      aInValid = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_ready0", {63'd0, aInReady}, 64'd0);
      @(negedge clk);
      checkOutput("post_rst_ready1", {63'd0, aInReady}, 64'd1);
      applyStimulus(40, 80, 80, 0);
      drainA("post_rst_drain");

      // Small-parameter instance: frame ends on vector 2 chunk 0
      checkOutput("b_done", {63'd0, bDone}, 64'd1);
      checkOutput("b_beats_logged", {63'd0, bLogData.size() >= 9}, 64'd1);
      if (bLogData.size() >= 9) begin
         checkOutput("b_beat2", {48'd0, bLogData[2]}, 64'h0002);
         checkOutput("b_beat3", {48'd0, bLogData[3]}, 64'h0010);
         checkOutput("b_beat5_last", {63'd0, bLogLast[5]}, 64'd0);
         checkOutput("b_beat6", {48'd0, bLogData[6]}, 64'h0020);
         checkOutput("b_beat6_last", {63'd0, bLogLast[6]}, 64'd1);
         checkOutput("b_beat7", {48'd0, bLogData[7]}, 64'h0030);
         checkOutput("b_beat7_last", {63'd0, bLogLast[7]}, 64'd0);
         checkOutput("b_beat8", {48'd0, bLogData[8]}, 64'h0031);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
